fb_page_scanner: RTL and testbench

Read-side sequencer for the 128x64 monochrome framebuffer. On `start`, it walks the framebuffer in OLED page order, issuing column reads (r_mode=1) through the framebuffer's read port. It bit-reorders each returned byte to the panel's LSB-is-top-row convention and presents the byte on a valid/ready stream to the OLED transport (SPI/I2C data path). It owns the framebuffer's re/r_xpos/r_ypos/r_mode inputs; the pixel-writing logic owns the write port.

---
 rtl/fb_page_scanner_if.sv | 28 ++
 rtl/fb_page_scanner.sv | 121 ++++++++++++
 tb/tb_fb_page_scanner.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_page_scanner_if.sv
// Framebuffer read port plus the page-byte stream toward the OLED transport.
// The scanner takes the master side; the framebuffer and the transport take the slave side.
interface fb_page_scanner_if;
    logic       fb_re;
    logic [7:0] fb_xpos;
    logic [7:0] fb_ypos;
    logic       fb_r_mode;
    logic [7:0] fb_dout;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;

    modport master (
        output fb_re, fb_xpos, fb_ypos, fb_r_mode,
        input  fb_dout,
        output out_data, out_valid, out_first, out_last,
        input  out_ready
    );

    modport slave (
        input  fb_re, fb_xpos, fb_ypos, fb_r_mode,
        output fb_dout,
        input  out_data, out_valid, out_first, out_last,
        output out_ready
    );
endinterface

// File: rtl/fb_page_scanner.sv
// Walks the framebuffer in OLED page order and streams LSB-is-top-row page bytes.
// Define FB_SCAN_INVERT_EN to emit inverse video (bitwise NOT of every byte).
module fb_page_scanner #(
    parameter int H_PIXELS = 128,
    parameter int V_PIXELS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    fb_page_scanner_if.master     bus
);
    localparam int         PAGES    = V_PIXELS / 8;
    localparam logic [7:0] COL_MAX  = 8'(H_PIXELS - 1);
    localparam logic [4:0] PAGE_MAX = 5'(PAGES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t     state, state_nxt;
    logic [7:0] col;
    logic [4:0] page;
    logic [7:0] out_data_q;
    logic       out_valid_q, out_first_q, out_last_q;
    logic [7:0] rev, fmt;
    logic       hs, is_last, kill;

    assign hs      = out_valid_q && bus.out_ready;
    assign is_last = (col == COL_MAX) && (page == PAGE_MAX);
    assign kill    = abort && (state != IDLE);

    // Framebuffer columns store the top row in the MSB; the panel wants it in bit 0.
    always_comb begin
        rev = '0;
        for (int i = 0; i < 8; i++) rev[i] = bus.fb_dout[7-i];
    end

`ifdef FB_SCAN_INVERT_EN
    assign fmt = ~rev;
`else
    assign fmt = rev;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (hs) state_nxt = is_last ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            page        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                col         <= '0;
                page        <= '0;
                out_valid_q <= 1'b0;
                out_first_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        col  <= '0;
                        page <= '0;
                    end
                    CAPTURE: begin
                        out_data_q  <= fmt;
                        out_valid_q <= 1'b1;
                        out_first_q <= (col == '0) && (page == '0);
                        out_last_q  <= is_last;
                    end
                    HOLD: if (hs) begin
                        out_valid_q <= 1'b0;
                        out_first_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (is_last) begin
                            done <= 1'b1;
                            col  <= '0;
                            page <= '0;
                        end else if (col == COL_MAX) begin
                            col  <= '0;
                            page <= page + 5'd1;
                        end else begin
                            col  <= col + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy          = (state != IDLE);
    assign bus.fb_re     = (state == ISSUE);
    assign bus.fb_xpos   = col;
    assign bus.fb_ypos   = {page, 3'b000};
    assign bus.fb_r_mode = 1'b1;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_fb_page_scanner.sv
// Bench for fb_page_scanner: random framebuffer contents, pixel-level reference model.
module tb_fb_page_scanner;
    localparam int H  = 128;
    localparam int V  = 64;
    localparam int NB = H * V / 8;
`ifdef FB_SCAN_INVERT_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic busy, done;
    fb_page_scanner_if bus();

    fb_page_scanner #(.H_PIXELS(H), .V_PIXELS(V)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Framebuffer: column byte per (page, x), MSB = top row of the page.
    logic [7:0] mem [0:7][0:127];
    always @(posedge clk)
        if (bus.fb_re) bus.fb_dout <= mem[int'(bus.fb_ypos) / 8][int'(bus.fb_xpos)];

    int n_cmp = 0, n_bad = 0;
    int idx, cyc = 0, n_re, overlaps, done_cnt, done_cyc, start_cyc, first_cnt;
    int stall_cnt = 0, abort_at = -1, rd_x, rd_y;
    bit stall_armed = 0, stall_bad, watch = 0, aborted, frame_done;
    logic [7:0] hold_data, b0, b261;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel (x,y) as stored in the framebuffer.
    function automatic logic pixel(input int x, input int y);
        logic [7:0] b;
        b = mem[y / 8][x];
        return b[7 - (y % 8)];
    endfunction

    // Panel byte #i in page order: bit k is row page*8+k of column x.
    function automatic logic [7:0] model_byte(input int i);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = pixel(i % H, (i / H) * 8 + k);
        return r ^ INV;
    endfunction

    task automatic cycle(input logic st, input logic ab, input logic rdy);
        @(negedge clk);
        start = st;
        abort = ab;
        if (stall_armed && bus.out_valid && idx == 127) begin
            stall_armed = 0;
            stall_cnt   = 10;
            hold_data   = bus.out_data;
            watch       = 1;
        end
        if (stall_cnt > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
            if (bus.out_data !== hold_data || bus.fb_re !== 1'b0 || bus.out_valid !== 1'b1) stall_bad = 1;
        end else begin
            bus.out_ready = rdy;
        end
        if (abort_at >= 0 && idx == abort_at && bus.out_valid) begin
            abort = 1'b1;
            bus.out_ready = 1'b0;
            abort_at = -1;
            aborted = 1;
        end
        #1;
        cyc++;
        if (bus.fb_re) n_re++;
        if (bus.fb_re && bus.out_valid) overlaps++;
        if (bus.fb_re && watch) begin
            rd_x = int'(bus.fb_xpos);
            rd_y = int'(bus.fb_ypos);
            watch = 0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            check($sformatf("byte%0d", idx), {22'd0, bus.out_first, bus.out_last, bus.out_data},
                  {22'd0, idx == 0, idx == NB - 1, model_byte(idx)});
            if (bus.out_first) first_cnt++;
            if (idx == 0) b0 = bus.out_data;
            if (idx == 261) b261 = bus.out_data;
            idx++;
        end
    endtask

    task automatic run_frame(input bit rnd, input bit b2b, input int max_cyc);
        frame_done = 0;
        for (int g = 0; g < max_cyc && !frame_done && !aborted; g++) begin
            logic rdy, st;
            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            st  = (b2b && idx == NB) || (idx < NB && $urandom_range(0, 40) == 0);
            cycle(st, 1'b0, rdy);
            if (done) frame_done = 1;
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int p = 0; p < 8; p++)
            for (int c = 0; c < H; c++) mem[p][c] = 8'($urandom);
        mem[0][0] = 8'h81;
        mem[2][5] = 8'hC0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_flags", {busy, done, bus.fb_re, bus.out_valid, bus.out_first, bus.out_last}, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_addr", {bus.fb_xpos, bus.fb_ypos}, 0);
        check("r_mode", bus.fb_r_mode, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: no reads; abort alone and start+abort are ignored.
        n_re = 0;
        repeat (50) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("idle_reads", n_re, 0);
        check("idle_busy", busy, 0);

        // Frame 1: ready held high, back-to-back start on done.
        idx = 0; done_cnt = 0; overlaps = 0; first_cnt = 0; aborted = 0;
        cycle(1'b1, 1'b0, 1'b1);
        start_cyc = cyc;
        check("busy_pre", busy, 0);
        cycle(1'b0, 1'b0, 1'b1);
        check("busy_rise", busy, 1);
        check("first_rd", {bus.fb_re, bus.fb_xpos, bus.fb_ypos}, {1'b1, 16'd0});
        run_frame(1'b0, 1'b1, 5000);
        check("f1_done", frame_done, 1);
        check("f1_bytes", idx, NB);
        check("f1_cycles", done_cyc - start_cyc - 1, 3072);
        check("f1_busy_at_done", busy, 0);
        check("byte0", b0, 8'h81 ^ INV);
        check("byte261", b261, 8'h03 ^ INV);
        check("f1_first_cnt", first_cnt, 1);

        // Frame 2: started by the back-to-back start; random ready plus a 10-cycle stall.
        idx = 0; stall_armed = 1; stall_bad = 0; rd_x = -1; rd_y = -1;
        cycle(1'b0, 1'b0, 1'b1);
        check("b2b_busy_done", {busy, done}, 2'b10);
        check("f1_done_width", done_cnt, 1);
        run_frame(1'b1, 1'b0, 12000);
        check("f2_done", frame_done, 1);
        check("f2_bytes", idx, NB);
        check("stall_seen", stall_armed, 0);
        check("stall_stable", stall_bad, 0);
        check("stall_next_rd", {rd_x[15:0], rd_y[15:0]}, {16'd0, 16'd8});
        repeat (3) cycle(1'b0, 1'b0, 1'b1);

        // Frame 3: abort while holding byte #500.
        idx = 0; abort_at = 500; aborted = 0; done_cnt = 0;
        cycle(1'b1, 1'b0, 1'b1);
        run_frame(1'b1, 1'b0, 8000);
        check("abort_hit", aborted, 1);
        cycle(1'b0, 1'b0, 1'b1);
        check("abort_outs", {bus.out_valid, busy, bus.fb_re, done}, 0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        check("abort_no_done", done_cnt, 0);

        // Frame 4: restart after abort begins from (0,0).
        idx = 0; aborted = 0; first_cnt = 0; b0 = 8'h00; watch = 1; rd_x = -1; rd_y = -1;
        cycle(1'b1, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, 5000);
        check("f4_done", frame_done, 1);
        check("f4_bytes", idx, NB);
        check("f4_first_rd", {rd_x[15:0], rd_y[15:0]}, 32'd0);
        check("f4_byte0", b0, 8'h81 ^ INV);
        check("f4_first_cnt", first_cnt, 1);
        check("overlap", overlaps, 0);

        // Asynchronous reset in the middle of a frame.
        idx = 0;
        cycle(1'b1, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_flags", {busy, done, bus.fb_re, bus.out_valid, bus.out_first, bus.out_last}, 0);
        check("async_rst_data", {bus.out_data, bus.fb_xpos, bus.fb_ypos}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_re = 0;
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        check("post_rst_idle", {busy, n_re[7:0]}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
